// File: rtl/aes_inv_sub_bytes.sv
// AES InvSubBytes on a 128-bit state with valid/ready on both sides.
// Default: word-serial (4 inverse S-boxes, 4 cycles/block); AES_INV_SUB_FAST_EN: 16 S-boxes, 1 block/cycle.
module aes_inv_sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine map, then GF(2^8) inversion as x^254 (maps 0 to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] sq;
        logic [7:0] acc;
        a   = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

`ifdef AES_INV_SUB_FAST_EN
    logic [127:0] sub_block;
    logic         out_valid_reg;
    logic [127:0] out_block_reg;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
            assign sub_block[8*gi +: 8] = inv_sbox(in_block[8*gi +: 8]);
        end
    endgenerate

    assign in_ready  = !out_valid_reg | out_ready;
    assign out_valid = out_valid_reg;
    assign out_block = out_block_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_block_reg <= '0;
        end else if (in_ready) begin
            out_valid_reg <= in_valid;
            if (in_valid) out_block_reg <= sub_block;
        end
    end
`else
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_reg;
    logic [1:0]   cnt_reg;
    logic [127:0] src_reg;
    logic [127:0] res_reg;
    logic [31:0]  lane_in;
    logic [31:0]  lane_out;
    logic         accept;

    assign lane_in = src_reg[{cnt_reg, 5'b0} +: 32];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_out[8*gi +: 8] = inv_sbox(lane_in[8*gi +: 8]);
        end
    endgenerate

    // DONE hands straight to BUSY when the result leaves and a new block arrives together.
    assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_reg == DONE);
    assign out_block = res_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            src_reg   <= '0;
            res_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        src_reg   <= in_block;
                        cnt_reg   <= 2'd0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    res_reg[{cnt_reg, 5'b0} +: 32] <= lane_out;
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) state_reg <= DONE;
                end
                DONE: begin
                    if (accept) begin
                        src_reg   <= in_block;
                        cnt_reg   <= 2'd0;
                        state_reg <= BUSY;
                    end else if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
`endif

endmodule
